// File: rtl/countdown_timer_pkg.sv
// rtl/countdown_timer_pkg.sv - shared types and widths for the countdown timer
package countdown_timer_pkg;

    // Operating modes of the timer
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int COUNT_W = 4;

    // Width of the tick counter that spans 0..tick_cycles-1
    function automatic int tick_width(input int tick_cycles);
        return $clog2(tick_cycles);
    endfunction

    // Width of a debounce counter that can hold db_cycles
    function automatic int db_width(input int db_cycles);
        return $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - operator-facing signals of the countdown timer
interface countdown_timer_if;
    import countdown_timer_pkg::*;

    logic [COUNT_W-1:0] load_val;
    logic               btn_load;
    logic               btn_start;
    logic [COUNT_W-1:0] led;
    logic               running;
    logic               done;

    modport master (
        output load_val, btn_load, btn_start,
        input  led, running, done
    );

    modport slave (
        input  load_val, btn_load, btn_start,
        output led, running, done
    );
endinterface

// File: rtl/countdown_timer_btn_debounce.sv
// rtl/countdown_timer_btn_debounce.sv - button synchroniser, debouncer and press pulse
module btn_debounce
    import countdown_timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    localparam int DB_W = db_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic            level;
    logic [DB_W-1:0] cnt;

    // Two-flop synchroniser for the raw asynchronous button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples; pulse on press only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else if (sync2 == level) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else if (cnt == DB_LAST) begin
            level <= sync2;
            cnt   <= '0;
            pulse <= sync2;
        end else begin
            cnt   <= cnt + 1'b1;
            pulse <= 1'b0;
        end
    end
endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable 4-bit once-per-tick countdown timer
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int CLK_HZ          = 12000000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic              clk,
    input  logic              rst_n,
    countdown_timer_if.slave  tif
);
    localparam int TICK_CYCLES = CLK_HZ / TICK_HZ;
    localparam int TICK_W      = tick_width(TICK_CYCLES);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    logic               load_p;
    logic               start_p;
    logic               tick;
    state_t             state, state_nxt;
    logic [COUNT_W-1:0] led_q, led_nxt;
    logic [TICK_W-1:0]  tick_cnt, tick_nxt;
    logic               running_q;
    logic               done_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (tif.btn_load),
        .pulse (load_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (tif.btn_start),
        .pulse (start_p)
    );

    // Next state, count and tick counter; LOAD beats START beats tick
    always_comb begin
        state_nxt = state;
        led_nxt   = led_q;
        tick_nxt  = tick_cnt;
        tick      = (state == ST_RUN) && (tick_cnt == TICK_LAST);

        if (state == ST_RUN) begin
            tick_nxt = tick ? '0 : tick_cnt + 1'b1;
        end

        if (load_p) begin
            led_nxt   = tif.load_val;
            state_nxt = ST_IDLE;
            tick_nxt  = '0;
        end else if (start_p) begin
            case (state)
                ST_IDLE: begin
                    tick_nxt  = '0;
                    state_nxt = (led_q != '0) ? ST_RUN : ST_DONE;
                end
                ST_RUN: begin
                    // Pausing discards a coincident tick and freezes the phase
                    tick_nxt  = tick_cnt;
                    state_nxt = ST_PAUSE;
                end
                ST_PAUSE: state_nxt = ST_RUN;
                default:  state_nxt = state;
            endcase
        end else if (tick) begin
            if (led_q > COUNT_W'(1)) begin
                led_nxt = led_q - 1'b1;
            end else begin
                led_nxt   = '0;
                state_nxt = ST_DONE;
            end
        end
    end

    // State, count and status registers; status flags track the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            led_q     <= '0;
            tick_cnt  <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            led_q     <= led_nxt;
            tick_cnt  <= tick_nxt;
            running_q <= (state_nxt == ST_RUN);
            done_q    <= (state_nxt == ST_DONE);
        end
    end

    assign tif.led     = led_q;
    assign tif.running = running_q;
    assign tif.done    = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed self-checking bench for countdown_timer
module tb_countdown_timer;
    logic clk;
    logic rst_n;
    int   vecs = 0;
    int   errs = 0;
    int   n_start = 0;
    int   n_load  = 0;

    countdown_timer_if tif ();

    countdown_timer #(
        .CLK_HZ          (20),
        .TICK_HZ         (1),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tif   (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dut.start_p === 1'b1) n_start++;
        if (dut.load_p === 1'b1)  n_load++;
    end

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_load(input logic [3:0] v);
        tif.load_val = v;
        tif.btn_load = 1'b1;
        tick_n(10);
        tif.btn_load = 1'b0;
        tick_n(10);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tif.load_val = 4'd0;
        tif.btn_load = 1'b0;
        tif.btn_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tif.btn_load  = ~tif.btn_load;
            tif.btn_start = ~tif.btn_start;
            vecs++;
            if (tif.led !== 4'd0 || tif.running !== 1'b0 || tif.done !== 1'b0) begin
                errs++;
                $display("FAIL reset_hold: led=%0d running=%0b done=%0b, want 0/0/0", tif.led, tif.running, tif.done);
            end
        end
        tif.btn_load = 1'b0;
        tif.btn_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick_n(10);
        vecs++;
        if (tif.led !== 4'd0 || tif.running !== 1'b0 || tif.done !== 1'b0) begin
            errs++;
            $display("FAIL reset_after: led=%0d running=%0b done=%0b, want 0/0/0", tif.led, tif.running, tif.done);
        end
        vecs++;
        if (n_start !== 0 || n_load !== 0) begin
            errs++;
            $display("FAIL reset_pulses: start=%0d load=%0d, want 0/0", n_start, n_load);
        end
    endtask

    task automatic test_load_count();
        int lat;
        press_load(4'd3);
        vecs++;
        if (tif.led !== 4'd3 || tif.running !== 1'b0 || tif.done !== 1'b0) begin
            errs++;
            $display("FAIL load3: led=%0d running=%0b done=%0b, want 3/0/0", tif.led, tif.running, tif.done);
        end
        tif.btn_start = 1'b1;
        lat = 0;
        while (tif.running !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        vecs++;
        if (lat !== 7) begin
            errs++;
            $display("FAIL start_latency: got %0d cycles, want 7", lat);
        end
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 3) tif.btn_start = 1'b0;
            if (i == 19 || i == 20 || i == 40 || i == 59 || i == 60) begin
                logic [3:0] el;
                logic       er, ed;
                el = (i == 19) ? 4'd3 : (i == 20) ? 4'd2 : (i == 60) ? 4'd0 : 4'd1;
                er = (i != 60);
                ed = (i == 60);
                vecs++;
                if (tif.led !== el || tif.running !== er || tif.done !== ed) begin
                    errs++;
                    $display("FAIL count_t%0d: led=%0d running=%0b done=%0b, want %0d/%0b/%0b",
                             i, tif.led, tif.running, tif.done, el, er, ed);
                end
            end
        end
    endtask

    task automatic test_bounce();
        int s0;
        press_load(4'd4);
        s0 = n_start;
        tif.btn_start = 1'b1; tick_n(2);
        tif.btn_start = 1'b0; tick_n(1);
        tif.btn_start = 1'b1; tick_n(3);
        tif.btn_start = 1'b0; tick_n(2);
        tif.btn_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 5) begin
                vecs++;
                if (dut.start_p !== 1'b0 || n_start !== s0 || tif.running !== 1'b0) begin
                    errs++;
                    $display("FAIL bounce_early: start_p=%0b pulses=%0d running=%0b, want 0/0/0",
                             dut.start_p, n_start - s0, tif.running);
                end
            end
            if (k == 6) begin
                vecs++;
                if (dut.start_p !== 1'b1) begin
                    errs++;
                    $display("FAIL bounce_pulse_time: start_p=%0b, want 1", dut.start_p);
                end
            end
            if (k == 7) begin
                vecs++;
                if (tif.running !== 1'b1 || tif.led !== 4'd4) begin
                    errs++;
                    $display("FAIL bounce_run: running=%0b led=%0d, want 1/4", tif.running, tif.led);
                end
            end
        end
        tif.btn_start = 1'b0;
        tick_n(12);
        vecs++;
        if (n_start - s0 !== 1) begin
            errs++;
            $display("FAIL bounce_count: got %0d pulses, want 1", n_start - s0);
        end
    endtask

    task automatic test_pause();
        int  lat;
        bit  bad;
        press_load(4'd5);
        tif.btn_start = 1'b1;
        lat = 0;
        while (tif.running !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        tif.btn_start = 1'b0;
        tick_n(6);
        tif.btn_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 6) begin
                vecs++;
                if (tif.running !== 1'b1 || tif.led !== 4'd5) begin
                    errs++;
                    $display("FAIL pause_before: running=%0b led=%0d, want 1/5", tif.running, tif.led);
                end
            end
            if (k == 7) begin
                vecs++;
                if (tif.running !== 1'b0 || tif.done !== 1'b0 || tif.led !== 4'd5) begin
                    errs++;
                    $display("FAIL pause_enter: running=%0b done=%0b led=%0d, want 0/0/5",
                             tif.running, tif.done, tif.led);
                end
            end
        end
        tif.btn_start = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 43; k++) begin
            @(negedge clk);
            if (tif.led !== 4'd5 || tif.running !== 1'b0) bad = 1'b1;
        end
        vecs++;
        if (bad) begin
            errs++;
            $display("FAIL pause_hold: led=%0d running=%0b, want 5/0 throughout", tif.led, tif.running);
        end
        tif.btn_start = 1'b1;
        lat = 0;
        while (tif.running !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        vecs++;
        if (lat !== 7) begin
            errs++;
            $display("FAIL resume_latency: got %0d cycles, want 7", lat);
        end
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (j == 3) tif.btn_start = 1'b0;
            if (j == 7) begin
                vecs++;
                if (tif.led !== 4'd5) begin
                    errs++;
                    $display("FAIL resume_t7: led=%0d, want 5", tif.led);
                end
            end
            if (j == 8) begin
                vecs++;
                if (tif.led !== 4'd4 || tif.running !== 1'b1) begin
                    errs++;
                    $display("FAIL resume_t8: led=%0d running=%0b, want 4/1", tif.led, tif.running);
                end
            end
        end
        tick_n(10);
    endtask

    task automatic test_zero_start();
        press_load(4'd0);
        vecs++;
        if (tif.led !== 4'd0 || tif.done !== 1'b0 || tif.running !== 1'b0) begin
            errs++;
            $display("FAIL zero_load: led=%0d done=%0b running=%0b, want 0/0/0", tif.led, tif.done, tif.running);
        end
        tif.btn_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 6) begin
                vecs++;
                if (tif.done !== 1'b0) begin
                    errs++;
                    $display("FAIL zero_early: done=%0b, want 0", tif.done);
                end
            end
            if (k == 7) begin
                vecs++;
                if (tif.done !== 1'b1 || tif.running !== 1'b0 || tif.led !== 4'd0) begin
                    errs++;
                    $display("FAIL zero_done: done=%0b running=%0b led=%0d, want 1/0/0",
                             tif.done, tif.running, tif.led);
                end
            end
        end
        tif.btn_start = 1'b0;
        tick_n(10);
        tif.btn_start = 1'b1;
        tick_n(10);
        tif.btn_start = 1'b0;
        tick_n(25);
        vecs++;
        if (tif.done !== 1'b1 || tif.running !== 1'b0 || tif.led !== 4'd0) begin
            errs++;
            $display("FAIL zero_restart: done=%0b running=%0b led=%0d, want 1/0/0",
                     tif.done, tif.running, tif.led);
        end
    endtask

    task automatic test_priority();
        int lat;
        press_load(4'd7);
        tif.btn_start = 1'b1;
        lat = 0;
        while (tif.running !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        tif.btn_start = 1'b0;
        tick_n(8);
        vecs++;
        if (tif.running !== 1'b1 || tif.led !== 4'd7) begin
            errs++;
            $display("FAIL prio_setup: running=%0b led=%0d, want 1/7", tif.running, tif.led);
        end
        tif.load_val  = 4'd9;
        tif.btn_load  = 1'b1;
        tif.btn_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 7) begin
                vecs++;
                if (tif.led !== 4'd9 || tif.running !== 1'b0 || tif.done !== 1'b0) begin
                    errs++;
                    $display("FAIL prio_load_wins: led=%0d running=%0b done=%0b, want 9/0/0",
                             tif.led, tif.running, tif.done);
                end
            end
        end
        tif.btn_load  = 1'b0;
        tif.btn_start = 1'b0;
        tick_n(30);
        vecs++;
        if (tif.led !== 4'd9 || tif.running !== 1'b0 || tif.done !== 1'b0) begin
            errs++;
            $display("FAIL prio_idle: led=%0d running=%0b done=%0b, want 9/0/0",
                     tif.led, tif.running, tif.done);
        end
    endtask

    initial begin
        test_reset();
        test_load_count();
        test_bounce();
        test_pause();
        test_zero_start();
        test_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
